// File: rtl/adt7420_sample_scheduler.sv
// adt7420_sample_scheduler
//
// Schedules ADT7420 temperature reads through an external I2C read engine.
// After reset it waits out the sensor power-up time. It then issues one read
// per sample period and retries failed reads at once. After MAX_RETRY
// consecutive failures it latches a fault until clear_fault. Good samples
// feed a moving average over 2**AVG_LOG2 entries.
//
// Ports
//   clk_100MHz    in   system clock
//   reset_n       in   synchronous active-low reset
//   enable        in   permits new reads (a read in flight always completes)
//   clear_fault   in   one-cycle pulse, leaves the fault state
//   rd_start      out  one-cycle pulse, starts an engine read
//   rd_busy       in   engine is mid-transaction
//   rd_done       in   one-cycle pulse, transaction finished
//   rd_nack       in   qualifies rd_done: 1 = transaction failed
//   rd_data       in   raw {MSB, LSB}, valid with rd_done
//   temp_avg      out  signed 13-bit temperature, 1/16 degC per LSB
//   temp_c_int    out  signed whole degrees, temp_avg[11:4]
//   sample_valid  out  one-cycle pulse per absorbed sample
//   avg_valid     out  averaging window full
//   sensor_fault  out  level, high while in the fault state
//   state_dbg     out  current FSM state encoding
//
// Engine handshake: rd_start is a single-cycle request and is only issued
// while rd_busy is low. The engine answers with exactly one rd_done pulse.
// rd_nack and rd_data are meaningful only in that rd_done cycle. An rd_done
// seen while no read is outstanding is ignored.

module adt7420_sample_scheduler #(
    parameter int POWER_UP_CYCLES = 1950,
    parameter int SAMPLE_PERIOD   = 10_000_000,
    parameter int TIMEOUT_CYCLES  = 200_000,
    parameter int MAX_RETRY       = 3,
    parameter int AVG_LOG2        = 2
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear_fault,
    output logic        rd_start,
    input  logic        rd_busy,
    input  logic        rd_done,
    input  logic        rd_nack,
    input  logic [15:0] rd_data,
    output logic [12:0] temp_avg,
    output logic [7:0]  temp_c_int,
    output logic        sample_valid,
    output logic        avg_valid,
    output logic        sensor_fault,
    output logic [2:0]  state_dbg
);

    localparam int PU_W   = (POWER_UP_CYCLES > 1) ? $clog2(POWER_UP_CYCLES) : 1;
    localparam int PER_W  = $clog2(SAMPLE_PERIOD);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);
    localparam int DEPTH  = 2 ** AVG_LOG2;
    localparam int ACC_W  = 13 + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    localparam logic [PU_W-1:0]   PU_LAST   = PU_W'(POWER_UP_CYCLES - 1);
    // rd_start is registered, so the go decision is taken one cycle before
    // the pulse; this keeps start-to-start spacing at SAMPLE_PERIOD.
    localparam logic [PER_W-1:0]  PER_GO    = PER_W'(SAMPLE_PERIOD - 2);
    localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_POWER_UP = 3'd0,
        S_START    = 3'd1,
        S_WAIT     = 3'd2,
        S_IDLE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t                   state;
    logic [PU_W-1:0]          pu_cnt;
    logic [PER_W-1:0]         period_cnt;
    logic [TMO_W-1:0]         tmo_cnt;
    logic [RTY_W-1:0]         retry_cnt;
    logic signed [12:0]       ring [DEPTH];
    logic [AVG_LOG2-1:0]      wr_ptr;
    logic [FILL_W-1:0]        fill_cnt;
    logic signed [ACC_W-1:0]  sum;

    logic signed [12:0]       sample;
    logic signed [12:0]       oldest;
    logic signed [ACC_W-1:0]  sum_next;
    logic signed [ACC_W-1:0]  sum_shift;
    logic [12:0]              avg_new;
    logic                     full_next;
    logic                     period_go;
    logic [RTY_W-1:0]         retry_inc;
    logic                     unused_lsbs;

    assign state_dbg   = state;
    assign unused_lsbs = ^rd_data[2:0];

    always_comb begin
        sample    = rd_data[15:3];
        oldest    = ring[wr_ptr];
        // Entries not yet written hold zero, so the subtraction is harmless
        // while the window is still filling.
        sum_next  = sum + {{AVG_LOG2{sample[12]}}, sample}
                        - {{AVG_LOG2{oldest[12]}}, oldest};
        sum_shift = sum_next >>> AVG_LOG2;
        full_next = (fill_cnt >= FILL_LAST);
        avg_new   = full_next ? sum_shift[12:0] : sample;
        period_go = (period_cnt >= PER_GO);
        retry_inc = retry_cnt + RTY_W'(1);
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state        <= S_POWER_UP;
            pu_cnt       <= '0;
            period_cnt   <= '0;
            tmo_cnt      <= '0;
            retry_cnt    <= '0;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            sum          <= '0;
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            rd_start     <= 1'b0;
            temp_avg     <= '0;
            temp_c_int   <= '0;
            sample_valid <= 1'b0;
            avg_valid    <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            rd_start     <= 1'b0;
            sample_valid <= 1'b0;

            // Period counter saturates so a long enable=0 stretch cannot wrap.
            if (state != S_POWER_UP && period_cnt != PER_MAX)
                period_cnt <= period_cnt + PER_W'(1);

            case (state)
                S_POWER_UP: begin
                    if (pu_cnt == PU_LAST) state <= S_START;
                    else                   pu_cnt <= pu_cnt + PU_W'(1);
                end

                S_START: begin
                    if (!rd_busy) begin
                        rd_start   <= 1'b1;
                        period_cnt <= '0;
                        tmo_cnt    <= '0;
                        state      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (rd_done && !rd_nack) begin
                        ring[wr_ptr] <= sample;
                        wr_ptr       <= wr_ptr + AVG_LOG2'(1);
                        sum          <= sum_next;
                        if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + FILL_W'(1);
                        temp_avg     <= avg_new;
                        temp_c_int   <= avg_new[11:4];
                        avg_valid    <= full_next;
                        sample_valid <= 1'b1;
                        retry_cnt    <= '0;
                        // Skip S_IDLE when the period has already elapsed so a
                        // slow read restarts 2 cycles after rd_done.
                        state        <= (period_go && enable) ? S_START : S_IDLE;
                    end else if (rd_done || tmo_cnt == TMO_LAST) begin
                        retry_cnt <= retry_inc;
                        if (retry_inc == RTY_MAX) begin
                            sensor_fault <= 1'b1;
                            state        <= S_FAULT;
                        end else begin
                            state <= S_START;
                        end
                    end
                end

                S_IDLE: begin
                    if (period_go && enable) state <= S_START;
                end

                S_FAULT: begin
                    if (clear_fault) begin
                        retry_cnt    <= '0;
                        wr_ptr       <= '0;
                        fill_cnt     <= '0;
                        sum          <= '0;
                        for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
                        temp_avg     <= '0;
                        temp_c_int   <= '0;
                        avg_valid    <= 1'b0;
                        sensor_fault <= 1'b0;
                        state        <= S_START;
                    end
                end

                default: state <= S_POWER_UP;
            endcase
        end
    end

endmodule

// File: tb/tb_adt7420_sample_scheduler.sv
// Directed testbench for adt7420_sample_scheduler with an averaging
// scoreboard. Cycle numbers count rising edges since reset release (cycle 0).
module tb_adt7420_sample_scheduler;

    localparam int PU  = 10;
    localparam int SP  = 100;
    localparam int TMO = 50;
    localparam int MR  = 3;
    localparam int AL  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, clear_fault, rd_busy, rd_done, rd_nack;
    logic [15:0] rd_data;
    logic        rd_start, sample_valid, avg_valid, sensor_fault;
    logic [12:0] temp_avg;
    logic [7:0]  temp_c_int;
    logic [2:0]  state_dbg;

    adt7420_sample_scheduler #(
        .POWER_UP_CYCLES(PU),
        .SAMPLE_PERIOD  (SP),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MR),
        .AVG_LOG2       (AL)
    ) dut (
        .clk_100MHz  (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear_fault (clear_fault),
        .rd_start    (rd_start),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .rd_nack     (rd_nack),
        .rd_data     (rd_data),
        .temp_avg    (temp_avg),
        .temp_c_int  (temp_c_int),
        .sample_valid(sample_valid),
        .avg_valid   (avg_valid),
        .sensor_fault(sensor_fault),
        .state_dbg   (state_dbg)
    );

    int cyc = -1;
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : -1;

    // ---------------- bookkeeping ----------------
    int          total = 0;
    int          bad = 0;
    int          sv_count = 0;
    int          start_count = 0;
    int          last_start = -1;
    int          pushes = 0;
    logic        prev_start = 1'b0;
    logic [21:0] exp_q[$];
    logic [21:0] last_exp = '0;
    logic [21:0] sb_e;
    int          win[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return 32'({rd_start, sample_valid, avg_valid, sensor_fault, temp_c_int, temp_avg});
    endfunction

    // Reference window: last four good samples; average is floor(sum/4) once full.
    task automatic model_push(input logic [15:0] data);
        logic [12:0] raw;
        logic [12:0] a13;
        logic        av;
        int          s, acc, avg;
        raw = data[15:3];
        s = $signed(raw);
        if (win.size() == 4) void'(win.pop_front());
        win.push_back(s);
        if (win.size() < 4) begin
            avg = s;
            av  = 1'b0;
        end else begin
            acc = 0;
            foreach (win[i]) acc += win[i];
            avg = acc >>> 2;
            av  = 1'b1;
        end
        a13 = avg[12:0];
        last_exp = {av, a13[11:4], a13};
        exp_q.push_back(last_exp);
        pushes++;
    endtask

    task automatic model_clear();
        win.delete();
        last_exp = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rd_start) begin
                at = cyc;
                break;
            end
        end
        total++;
        assert (at >= 0) else begin
            bad++;
            $error("FAIL start_wait: observed=none expected=rd_start within %0d cycles", budget);
        end
    endtask

    task automatic respond(input logic [15:0] data, input logic nack, input int lat, output int d);
        rd_busy = 1'b1;
        repeat (lat) tick();
        rd_busy = 1'b0;
        rd_done = 1'b1;
        rd_nack = nack;
        rd_data = data;
        d = cyc;
        if (!nack) model_push(data);
        tick();
        rd_done = 1'b0;
        rd_nack = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rd_start) begin
            start_count++;
            last_start = cyc;
            check("start_single_cycle", 32'(prev_start), 0);
        end
        prev_start = rd_start;
        if (sample_valid) begin
            sv_count++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_unexpected: observed=sample_valid expected=no sample cycle=%0d", cyc);
            end
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_sample", 32'({avg_valid, temp_c_int, temp_avg}), 32'(sb_e));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int at, prev, d, c, t, sc, svc;
        reset_n = 1'b0; enable = 1'b1; clear_fault = 1'b0;
        rd_busy = 1'b0; rd_done = 1'b0; rd_nack = 1'b0; rd_data = '0;
        repeat (3) tick();
        check("reset_outputs", outs(), 0);

        // power-up wait
        reset_n = 1'b1;
        for (int i = 0; i < PU; i++) begin
            tick();
            check("powerup_quiet", outs(), 0);
        end
        wait_start(5, at);
        check("first_start", at, PU);
        prev = at;

        // positive averaging: 400, 400, 400, 432
        respond(16'h0C80, 1'b0, 20, d);
        wait_start(200, at); check("period_start", at - prev, SP); prev = at;
        respond(16'h0C80, 1'b0, 15, d);
        wait_start(200, at); check("period_start", at - prev, SP); prev = at;
        respond(16'h0C80, 1'b0, 30, d);
        tick();
        check("avg_partial_value", temp_avg, 400);
        check("avg_partial_valid", avg_valid, 0);
        wait_start(200, at); check("period_start", at - prev, SP); prev = at;
        respond(16'h0D80, 1'b0, 25, d);
        tick();
        check("avg_full_value", temp_avg, 408);
        check("avg_full_cint", temp_c_int, 25);
        check("avg_full_valid", avg_valid, 1);
        check("sample_per_read", sv_count, 4);

        // negative averaging: four reads of -800
        for (int k = 0; k < 4; k++) begin
            wait_start(200, at); check("period_start", at - prev, SP); prev = at;
            respond(16'hE700, 1'b0, 10 + k * 5, d);
        end
        tick();
        check("avg_neg_value", temp_avg, 32'h1CE0);
        check("avg_neg_cint", temp_c_int, 32'hCE);

        // NACK retries then a good read
        wait_start(200, at); check("period_start", at - prev, SP);
        svc = sv_count;
        respond(16'h0000, 1'b1, 8, d);
        wait_start(10, at); check("nack_retry1_gap", at - d, 2);
        respond(16'h0000, 1'b1, 6, d);
        wait_start(10, at); check("nack_retry2_gap", at - d, 2);
        prev = at;
        respond(16'h0C80, 1'b0, 12, d);
        tick();
        check("nack_no_fault", sensor_fault, 0);
        check("nack_one_sample", sv_count - svc, 1);

        // timeout retries into fault
        wait_start(200, t); check("period_after_retry", t - prev, SP);
        wait_start(80, at); check("tmo_retry1", at - t, TMO + 1);
        wait_start(80, at); check("tmo_retry2", at - t, 2 * (TMO + 1));
        while (cyc < t + 153) tick();
        check("fault_set", sensor_fault, 1);
        sc = start_count; svc = sv_count;
        rd_done = 1'b1; rd_data = 16'h1900;
        tick();
        rd_done = 1'b0;
        repeat (60) tick();
        check("fault_no_start", start_count, sc);
        check("fault_ignores_done", sv_count, svc);
        check("fault_holds_avg", temp_avg, 32'(last_exp[12:0]));
        check("fault_held", sensor_fault, 1);

        // clear_fault restarts reading with an empty window
        c = cyc;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        tick(); tick();
        check("clear_one_start", start_count - sc, 1);
        check("clear_start_latency", 32'((last_start - c >= 1) && (last_start - c <= 2)), 1);
        check("clear_fault_low", sensor_fault, 0);
        check("clear_avg_valid", avg_valid, 0);
        check("clear_temp_avg", temp_avg, 0);
        model_clear();
        prev = last_start;
        respond(16'h0C80, 1'b0, 10, d);

        // enable dropped mid-read
        wait_start(200, at); check("period_after_clear", at - prev, SP);
        enable = 1'b0;
        svc = sv_count;
        respond(16'h1900, 1'b0, 10, d);
        tick();
        check("enable_low_completes", sv_count - svc, 1);
        sc = start_count;
        repeat (150) tick();
        check("enable_low_no_start", start_count, sc);
        c = cyc;
        enable = 1'b1;
        wait_start(5, at);
        check("enable_resume", 32'((at - c >= 1) && (at - c <= 3)), 1);

        // reset in the middle of a read
        rd_busy = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check("reset_mid_outputs", outs(), 0);
        rd_busy = 1'b0;
        reset_n = 1'b1;
        model_clear();
        for (int i = 0; i < PU; i++) begin
            tick();
            check("repower_quiet", outs(), 0);
            if (i == 3) begin
                rd_done = 1'b1;
                rd_data = 16'h0C80;
            end
            if (i == 4) rd_done = 1'b0;
        end
        wait_start(5, at);
        check("restart_powerup", at, PU);
        respond(16'hE700, 1'b0, 10, d);
        tick();
        check("post_reset_avg", temp_avg, 32'h1CE0);
        check("post_reset_valid", avg_valid, 0);

        repeat (5) tick();
        check("sb_drained", exp_q.size(), 0);
        check("sb_count", sv_count, pushes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
